// File: rtl/mcpu_pkg.sv
// Shared definitions for the fetch unit: FSM state type and the jump-class opcodes.
package mcpu_pkg;

    localparam int unsigned AnchoOpcode = 6;

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StExec,
        StHalt
    } estado_e;

    localparam logic [AnchoOpcode-1:0] OpJ    = 6'b111100;
    localparam logic [AnchoOpcode-1:0] OpJz   = 6'b111101;
    localparam logic [AnchoOpcode-1:0] OpJnz  = 6'b111110;
    localparam logic [AnchoOpcode-1:0] OpHalt = 6'b111111;

endpackage

// File: rtl/registro_pc.sv
// Program counter register: asynchronous clear, parallel load, increment modulo 2^Ancho.
module registro_pc #(
    parameter int unsigned Ancho = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             carga_i,
    input  logic             inc_i,
    input  logic [Ancho-1:0] dato_i,
    output logic [Ancho-1:0] pc_o
);

    localparam logic [Ancho-1:0] Uno = 1;

    logic [Ancho-1:0] pc_q, pc_d;

    // Load wins over increment; the adder wraps naturally at the top address.
    always_comb begin
        pc_d = pc_q;
        if (carga_i) begin
            pc_d = dato_i;
        end else if (inc_i) begin
            pc_d = pc_q + Uno;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/unidad_fetch.sv
// Instruction fetch unit: FETCH/WAIT/EXEC/HALT sequencer with instruction register and PC update.
module unidad_fetch
    import mcpu_pkg::*;
#(
    parameter int unsigned ANCHO_PC    = 10,
    parameter int unsigned ANCHO_INSTR = 16
) (
    input  logic                   reloj,
    input  logic                   reset,
    input  logic                   s_inc,
    input  logic                   zero,
    input  logic                   mem_ack,
    input  logic [ANCHO_INSTR-1:0] mem_data,
    output logic                   mem_req,
    output logic [ANCHO_PC-1:0]    mem_addr,
    output logic [AnchoOpcode-1:0] opcode,
    output logic                   instr_valid,
    output logic [ANCHO_PC-1:0]    pc,
    output logic                   halted
);

    estado_e                estado_q, estado_d;
    logic                   arranque_q;
    logic [ANCHO_INSTR-1:0] ir_q;
    logic                   carga_pc;
    logic                   inc_pc;
    logic [ANCHO_PC-1:0]    destino;

    assign opcode  = ir_q[ANCHO_INSTR-1 -: AnchoOpcode];
    assign destino = ir_q[ANCHO_PC-1:0];

    // arranque_q holds the first post-reset cycle in a quiet FETCH with no request raised.
    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            estado_q   <= StFetch;
            arranque_q <= 1'b0;
            ir_q       <= '0;
        end else begin
            estado_q   <= estado_d;
            arranque_q <= 1'b1;
            if (estado_q == StWait && mem_ack) begin
                ir_q <= mem_data;
            end
        end
    end

    always_comb begin
        estado_d    = estado_q;
        carga_pc    = 1'b0;
        inc_pc      = 1'b0;
        mem_req     = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        unique case (estado_q)
            StFetch: begin
                mem_req = arranque_q;
                if (arranque_q) begin
                    estado_d = StWait;
                end
            end
            StWait: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    estado_d = StExec;
                end
            end
            StExec: begin
                instr_valid = 1'b1;
                estado_d    = StFetch;
                if (s_inc) begin
                    inc_pc = 1'b1;
                end else begin
                    case (opcode)
                        OpJ:     carga_pc = 1'b1;
                        OpJz:    begin carga_pc = zero;  inc_pc = !zero; end
                        OpJnz:   begin carga_pc = !zero; inc_pc = zero;  end
                        // OpHalt and every non-jump opcode stop the machine with pc frozen.
                        default: estado_d = StHalt;
                    endcase
                end
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                estado_d = StFetch;
            end
        endcase
    end

    registro_pc #(
        .Ancho (ANCHO_PC)
    ) u_registro_pc (
        .clk_i   (reloj),
        .rst_ni  (reset),
        .carga_i (carga_pc),
        .inc_i   (inc_pc),
        .dato_i  (destino),
        .pc_o    (pc)
    );

    assign mem_addr = pc;

endmodule

// File: tb/tb_unidad_fetch.sv
// Self-checking bench for unidad_fetch: vector table, directed corner sequences, random program.
module tb_unidad_fetch;

    logic        reloj;
    logic        reset;
    logic        s_inc;
    logic        zero;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [9:0]  pc;
    logic        halted;

    int vectors = 0;
    int miscompares = 0;
    logic [5:0] last_op;

    unidad_fetch #(
        .ANCHO_PC    (10),
        .ANCHO_INSTR (16)
    ) dut (
        .reloj       (reloj),
        .reset       (reset),
        .s_inc       (s_inc),
        .zero        (zero),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .pc          (pc),
        .halted      (halted)
    );

    initial begin
        reloj = 1'b0;
        forever #5 reloj = ~reloj;
    end

    typedef struct {
        logic [15:0] word;
        logic        s_inc;
        logic        zero;
        logic [9:0]  pc_next;
        logic        halt;
    } vec_t;

    vec_t tabla[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    // Reference: next pc and halt decision from the instruction rules.
    task automatic ref_next(input int pc_in, input logic [15:0] word, input logic si,
                            input logic z, output int npc, output logic halt);
        int op;
        int tgt;
        int seq;
        op   = int'(word) / 1024;
        tgt  = int'(word) % 1024;
        seq  = (pc_in + 1) % 1024;
        halt = 1'b0;
        if (si) npc = seq;
        else if (op == 60) npc = tgt;
        else if (op == 61) npc = z ? tgt : seq;
        else if (op == 62) npc = z ? seq : tgt;
        else begin
            npc  = pc_in;
            halt = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        mem_ack = 1'b0;
        #3;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        last_op = 6'd0;
        @(negedge reloj);
        mem_ack  = 1'b1;
        mem_data = 16'hFFFF;
        reset    = 1'b1;
        #1;
        chk("rel_req_quiet", 32'(mem_req), 32'd0);
        tick();
        chk("rel_fetch_req", 32'(mem_req), 32'd1);
        chk("rel_fetch_addr", 32'(mem_addr), 32'd0);
        chk("rel_opcode", 32'(opcode), 32'd0);
    endtask

    // Starts in FETCH, serves one instruction after `delay` idle WAIT cycles, checks the outcome.
    task automatic run_instr(input string tag, input logic [15:0] word, input logic si,
                             input logic z, input int delay, input logic [9:0] exp_addr,
                             input logic [9:0] exp_pc, input logic exp_halt);
        int reqs;
        logic [5:0] op;
        reqs = 0;
        op   = word[15:10];
        chk({tag, ".fetch_req"}, 32'(mem_req), 32'd1);
        chk({tag, ".fetch_addr"}, 32'(mem_addr), 32'(exp_addr));
        chk({tag, ".fetch_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, ".fetch_op"}, 32'(opcode), 32'(last_op));
        if (mem_req) reqs++;
        mem_ack  = 1'($urandom_range(0, 1));
        mem_data = 16'($urandom);
        tick();
        for (int k = 0; k <= delay; k++) begin
            chk({tag, ".wait_req"}, 32'(mem_req), 32'd1);
            chk({tag, ".wait_addr"}, 32'(mem_addr), 32'(exp_addr));
            chk({tag, ".wait_valid"}, 32'(instr_valid), 32'd0);
            if (mem_req) reqs++;
            if (k == delay) begin
                mem_ack  = 1'b1;
                mem_data = word;
            end else begin
                mem_ack  = 1'b0;
                mem_data = 16'($urandom);
            end
            tick();
        end
        mem_ack  = 1'($urandom_range(0, 1));
        mem_data = 16'($urandom);
        s_inc    = si;
        zero     = z;
        chk({tag, ".exec_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, ".exec_op"}, 32'(opcode), 32'(op));
        chk({tag, ".exec_req"}, 32'(mem_req), 32'd0);
        last_op = op;
        tick();
        mem_ack = 1'b0;
        chk({tag, ".next_pc"}, 32'(pc), 32'(exp_pc));
        chk({tag, ".next_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, ".next_halted"}, 32'(halted), 32'(exp_halt));
        chk({tag, ".next_req"}, 32'(mem_req), 32'(!exp_halt));
        if (!exp_halt) chk({tag, ".next_addr"}, 32'(mem_addr), 32'(exp_pc));
        chk({tag, ".req_cycles"}, 32'(reqs), 32'(delay + 2));
    endtask

    initial begin
        logic [9:0]  prev_pc;
        logic [9:0]  pc_m;
        int          npc;
        logic        h;
        logic [5:0]  rop;
        logic [15:0] rword;
        logic        rsi;
        logic        rz;

        reset    = 1'b0;
        s_inc    = 1'b1;
        zero     = 1'b0;
        mem_ack  = 1'b0;
        mem_data = 16'h0000;
        last_op  = 6'd0;

        tabla[0]  = '{16'h0000, 1'b1, 1'b0, 10'h001, 1'b0};
        tabla[1]  = '{16'hF155, 1'b0, 1'b0, 10'h155, 1'b0};
        tabla[2]  = '{16'hF4AA, 1'b0, 1'b1, 10'h0AA, 1'b0};
        tabla[3]  = '{16'hF600, 1'b0, 1'b0, 10'h0AB, 1'b0};
        tabla[4]  = '{16'hFBFF, 1'b0, 1'b0, 10'h3FF, 1'b0};
        tabla[5]  = '{16'h1234, 1'b1, 1'b1, 10'h000, 1'b0};
        tabla[6]  = '{16'hF923, 1'b0, 1'b1, 10'h001, 1'b0};
        tabla[7]  = '{16'hF001, 1'b0, 1'b0, 10'h001, 1'b0};
        tabla[8]  = '{16'hFC00, 1'b1, 1'b0, 10'h002, 1'b0};
        tabla[9]  = '{16'hF555, 1'b0, 1'b1, 10'h155, 1'b0};
        tabla[10] = '{16'hF555, 1'b0, 1'b0, 10'h156, 1'b0};
        tabla[11] = '{16'h8ABC, 1'b0, 1'b0, 10'h156, 1'b1};

        #12;
        do_reset();
        prev_pc = 10'h000;
        for (int i = 0; i < 12; i++) begin
            run_instr($sformatf("tab%0d", i), tabla[i].word, tabla[i].s_inc, tabla[i].zero,
                      i % 3, prev_pc, tabla[i].pc_next, tabla[i].halt);
            prev_pc = tabla[i].pc_next;
        end

        // HALT is absorbing: no requests, pc frozen, acks ignored.
        do_reset();
        run_instr("halt", 16'hFC00, 1'b0, 1'b0, 0, 10'h000, 10'h000, 1'b1);
        for (int k = 0; k < 20; k++) begin
            mem_ack = 1'($urandom_range(0, 1));
            s_inc   = 1'($urandom_range(0, 1));
            tick();
            chk("halt_stay", 32'(halted), 32'd1);
            chk("halt_req", 32'(mem_req), 32'd0);
            chk("halt_pc", 32'(pc), 32'd0);
        end
        do_reset();

        // Slow memory: request held across FETCH plus five WAIT cycles.
        run_instr("slow", 16'h0000, 1'b1, 1'b0, 4, 10'h000, 10'h001, 1'b0);

        // Reset in the middle of WAIT with an ack pulsed while reset is held.
        run_instr("prejump", 16'hF155, 1'b0, 1'b0, 0, 10'h001, 10'h155, 1'b0);
        mem_ack = 1'b0;
        tick();
        chk("midwait_req", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_pc", 32'(pc), 32'd0);
        chk("midrst_opcode", 32'(opcode), 32'd0);
        mem_ack  = 1'b1;
        mem_data = 16'hF155;
        repeat (2) @(posedge reloj);
        @(negedge reloj);
        reset = 1'b1;
        #1;
        chk("midrel_req", 32'(mem_req), 32'd0);
        tick();
        chk("midrel_req_up", 32'(mem_req), 32'd1);
        chk("midrel_addr", 32'(mem_addr), 32'd0);
        chk("midrel_opcode", 32'(opcode), 32'd0);
        chk("midrel_valid", 32'(instr_valid), 32'd0);
        last_op = 6'd0;
        run_instr("restart", 16'h0400, 1'b1, 1'b0, 1, 10'h000, 10'h001, 1'b0);

        // Random program against the reference rules.
        do_reset();
        pc_m = 10'h000;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) != 0) rop = 6'd60 + 6'($urandom_range(0, 2));
            else rop = 6'($urandom);
            rword = {rop, 10'($urandom)};
            rsi   = ($urandom_range(0, 3) == 0);
            rz    = 1'($urandom_range(0, 1));
            ref_next(int'(pc_m), rword, rsi, rz, npc, h);
            run_instr($sformatf("rnd%0d", n), rword, rsi, rz, int'($urandom_range(0, 3)),
                      pc_m, 10'(npc), h);
            if (h) begin
                do_reset();
                pc_m = 10'h000;
            end else begin
                pc_m = 10'(npc);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/unidad_fetch.md
UNIDAD_FETCH -- requirements
Module: unidad_fetch

Interface
REQ-001 Parameter ANCHO_PC, default 10, program counter and instruction-memory address width.
REQ-002 Parameter ANCHO_INSTR, default 16, instruction word width; opcode in [ANCHO_INSTR-1 -: 6], jump target in [ANCHO_PC-1:0].
REQ-003 reloj  in  1  single clock, all state updates on rising edge.
REQ-004 reset  in  1  reset is asynchronous and active-low.
REQ-005 s_inc  in  1  from control unit: 1 = sequential PC+1, 0 = jump class instruction.
REQ-006 zero  in  1  registered ALU zero flag from datapath, sampled during EXEC.
REQ-007 mem_ack  in  1  instruction memory read acknowledge; mem_data valid when high.
REQ-008 mem_data  in  ANCHO_INSTR  instruction word from memory.
REQ-009 mem_req  out  1  read request, held until acknowledged.
REQ-010 mem_addr  out  ANCHO_PC  read address, equals pc while mem_req high.
REQ-011 opcode  out  6  instruction register opcode field, stable from EXEC entry until next EXEC entry.
REQ-012 instr_valid  out  1  high exactly during EXEC, qualifies opcode for control unit.
REQ-013 pc  out  ANCHO_PC  current program counter.
REQ-014 halted  out  1  high while in HALT state.

Function
REQ-015 FSM states SHALL be FETCH, WAIT, EXEC, HALT; registered, one-hot or binary at implementer's choice.
REQ-016 FETCH: mem_req=1, mem_addr=pc; next state WAIT unconditionally.
REQ-017 WAIT: mem_req=1 held; on rising edge with mem_ack=1 capture mem_data into instruction register, go EXEC; mem_ack=0 stays WAIT indefinitely.
REQ-018 mem_req SHALL be 0 in EXEC and HALT; mem_ack outside WAIT ignored.
REQ-019 Fetch latency: minimum 3 cycles per instruction (FETCH, WAIT with ack, EXEC).
REQ-020 EXEC lasts exactly one cycle; next PC computed from s_inc, zero, opcode sampled that cycle.
REQ-021 s_inc=1: pc <= pc+1, modulo 2^ANCHO_PC (max value wraps to 0), next FETCH.
REQ-022 s_inc=0, opcode 111100 (J): pc <= target; 111101 (JZ): target if zero=1 else pc+1; 111110 (JNZ): target if zero=0 else pc+1; next FETCH.
REQ-023 s_inc=0, opcode 111111 (HALT) or any opcode not 1111xx: pc unchanged, next HALT.
REQ-024 HALT is absorbing; only reset exits.
REQ-025 Jump target to own address SHALL re-fetch same instruction (no special-casing).

Reset
REQ-026 reset low SHALL immediately force state FETCH-pending: pc=0, instruction register=0, mem_req=0, instr_valid=0, halted=0, opcode=000000.
REQ-027 On first rising edge after reset release, state FETCH with mem_addr=0.
REQ-028 Reset asserted mid-WAIT abandons request; late mem_ack after release before FETCH SHALL be ignored.

Structure
REQ-029 Package mcpu_pkg holds FSM state typedef, jump opcode constants (J, JZ, JNZ, HALT) and opcode field width 6.
REQ-030 One sub-module registro_pc: PC register with async active-low clear, load and increment enables.

Verification
REQ-031 Reset release, memory acks after 1 cycle, three sequential instructions (s_inc=1) -> pc 0,1,2,3; instr_valid pulses every 3 cycles.
REQ-032 EXEC with s_inc=0, opcode 111101, target 0x155, zero=1 -> pc=0x155; repeat zero=0 -> pc=old+1.
REQ-033 mem_ack delayed 5 cycles -> mem_req and mem_addr stable 6 cycles, instr_valid stays 0 until capture.
REQ-034 pc=0x3FF, s_inc=1 -> pc wraps to 0x000, next mem_addr=0.
REQ-035 opcode 111111 -> halted=1, mem_req stays 0 for 20 cycles; reset low -> halted=0, pc=0.
REQ-036 reset asserted during WAIT, mem_ack pulsed during reset -> mem_req=0 at once, no instruction captured, fetch restarts at address 0.
